// File: rtl/clk_gen_pkg.sv
// Shared types and sizing helpers for the PHY clock-tree controller.
// Used by clk_gen_ctrl and by the optional clk_gen_shadow checker
// (CLK_GEN_CHECK_EN).
package clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int DEF_DIV_4F     = 8;
    localparam int DEF_SETTLE_CYC = 4;

    // L: log2 of the clk_32f cycles per clk_4f period.
    function automatic int div_log2(input int div);
        return $clog2(div);
    endfunction

    // The phase counter spans one clk_f period: L+2 bits.
    function automatic int cnt_width(input int div);
        return div_log2(div) + 2;
    endfunction

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int min1_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DIV_4F);

endpackage

// File: rtl/clk_gen_shadow.sv
// Independent shadow divider that cross-checks the clock outputs of
// clk_gen_ctrl. Built only when CLK_GEN_CHECK_EN is defined.
`ifdef CLK_GEN_CHECK_EN
module clk_gen_shadow
    import clk_gen_pkg::*;
#(
    parameter int DIV_4F = DEF_DIV_4F
) (
    input  logic clk_32f,
    input  logic reset,
    input  logic run_entry,   // edge that moves SETTLE -> RUN
    input  logic active,      // current cycle is RUN or DRAIN
    input  logic clk_4f,
    input  logic clk_2f,
    input  logic clk_f,
    output logic err
);
    localparam int HALF = DIV_4F / 2;
    localparam int HW   = min1_width(HALF);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

    logic [HW-1:0] half_q;
    logic          sh_4f_q, sh_2f_q, sh_f_q, err_q;
    logic          tog_4f, tog_2f, tog_f;

    // A slower clock changes phase exactly when the next-faster one starts a
    // new high phase (its underlying divider bit falls), so it toggles when
    // the faster shadow clock is low and about to toggle.
    always_comb begin
        tog_4f = (half_q == HALF_LAST);
        tog_2f = tog_4f & ~sh_4f_q;
        tog_f  = tog_2f & ~sh_2f_q;
    end

    // Shadow toggle flops: preset high on RUN entry, free-run in RUN/DRAIN.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            half_q  <= '0;
            sh_4f_q <= 1'b0;
            sh_2f_q <= 1'b0;
            sh_f_q  <= 1'b0;
        end else if (run_entry) begin
            half_q  <= '0;
            sh_4f_q <= 1'b1;
            sh_2f_q <= 1'b1;
            sh_f_q  <= 1'b1;
        end else if (active) begin
            half_q  <= tog_4f ? '0 : half_q + HW'(1);
            sh_4f_q <= sh_4f_q ^ tog_4f;
            sh_2f_q <= sh_2f_q ^ tog_2f;
            sh_f_q  <= sh_f_q ^ tog_f;
        end
    end

    // Sticky error: any RUN/DRAIN cycle where an output disagrees with its shadow.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (active && ({clk_4f, clk_2f, clk_f} != {sh_4f_q, sh_2f_q, sh_f_q})) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule
`endif

// File: rtl/clk_gen_ctrl.sv
// PHY clock-tree controller: sequences IDLE/SETTLE/RUN/DRAIN and generates
// clk_4f, clk_2f, clk_f plus their rise strobes from clk_32f.
// Optional macro CLK_GEN_CHECK_EN adds the err port and a shadow divider.
module clk_gen_ctrl
    import clk_gen_pkg::*;
#(
    parameter int DIV_4F     = DEF_DIV_4F,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk_32f,
    input  logic reset,
    input  logic enable,
    output logic clk_4f,
    output logic clk_2f,
    output logic clk_f,
    output logic stb_4f,
    output logic stb_2f,
    output logic stb_f,
    output logic locked,
    output logic busy
`ifdef CLK_GEN_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int L  = div_log2(DIV_4F);
    localparam int CW = cnt_width(DIV_4F);
    localparam int SW = min1_width(SETTLE_CYC);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          active_d;
    logic          clk_4f_q, clk_2f_q, clk_f_q;
    logic          stb_4f_q, stb_2f_q, stb_f_q;

    // Next state, settle count and phase count.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        settle_d = '0;
        cnt_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable)                    state_d  = ST_IDLE;
                else if (settle_q == SETTLE_LAST) state_d  = ST_RUN;
                else                            settle_d = settle_q + SW'(1);
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                // Re-entry wins over the stop when both happen together.
                if (enable) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_MAX) begin
                    // All clocks are low at cnt==all-ones, so stopping here is glitch-free.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // State, counters and the dedicated output flops, all aligned with cnt.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            clk_4f_q <= 1'b0;
            clk_2f_q <= 1'b0;
            clk_f_q  <= 1'b0;
            stb_4f_q <= 1'b0;
            stb_2f_q <= 1'b0;
            stb_f_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            clk_4f_q <= active_d & ~cnt_d[L-1];
            clk_2f_q <= active_d & ~cnt_d[L];
            clk_f_q  <= active_d & ~cnt_d[L+1];
            stb_4f_q <= active_d & (cnt_d[L-1:0] == '0);
            stb_2f_q <= active_d & (cnt_d[L:0] == '0);
            stb_f_q  <= active_d & (cnt_d == '0);
        end
    end

    assign clk_4f = clk_4f_q;
    assign clk_2f = clk_2f_q;
    assign clk_f  = clk_f_q;
    assign stb_4f = stb_4f_q;
    assign stb_2f = stb_2f_q;
    assign stb_f  = stb_f_q;
    assign locked = (state_q == ST_RUN);
    assign busy   = (state_q != ST_IDLE);

`ifdef CLK_GEN_CHECK_EN
    logic run_entry, active_q;

    assign run_entry = (state_q == ST_SETTLE) && (state_d == ST_RUN);
    assign active_q  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    clk_gen_shadow #(
        .DIV_4F(DIV_4F)
    ) u_shadow (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .run_entry(run_entry),
        .active   (active_q),
        .clk_4f   (clk_4f),
        .clk_2f   (clk_2f),
        .clk_f    (clk_f),
        .err      (err)
    );
`endif

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed testbench for clk_gen_ctrl with DIV_4F=8, SETTLE_CYC=4.
// Outputs are sampled on the falling edge of clk_32f.
module tb_clk_gen_ctrl;
    localparam int DIV_4F     = 8;
    localparam int SETTLE_CYC = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    logic enable  = 1'b1;
    logic clk_4f, clk_2f, clk_f, stb_4f, stb_2f, stb_f, locked, busy;
`ifdef CLK_GEN_CHECK_EN
    logic err;
`endif

    int checks = 0;
    int errors = 0;
    int k      = 0;   // expected cnt value of the current RUN/DRAIN sample

    always #5 clk_32f = ~clk_32f;

    clk_gen_ctrl #(
        .DIV_4F    (DIV_4F),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .enable (enable),
        .clk_4f (clk_4f),
        .clk_2f (clk_2f),
        .clk_f  (clk_f),
        .stb_4f (stb_4f),
        .stb_2f (stb_2f),
        .stb_f  (stb_f),
        .locked (locked),
        .busy   (busy)
`ifdef CLK_GEN_CHECK_EN
        ,
        .err    (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {clk_4f, clk_2f, clk_f, stb_4f, stb_2f, stb_f, locked, busy}
    function automatic logic [7:0] outs();
        return {clk_4f, clk_2f, clk_f, stb_4f, stb_2f, stb_f, locked, busy};
    endfunction

    // Expected outputs at phase count n: clk_4f 4 high/4 low, clk_2f 8/8,
    // clk_f 16/16, each high first; strobes on the first high cycle.
    function automatic logic [7:0] run_vec(input int n, input logic lk);
        int p;
        p = n % 32;
        return {(p % 8) < 4, (p % 16) < 8, p < 16,
                (p % 8) == 0, (p % 16) == 0, p == 0, lk, 1'b1};
    endfunction

    task automatic cyc();
        @(negedge clk_32f);
    endtask

    task automatic expect_settle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            check("settle", 32'(outs()), 32'h01);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            check(tag, 32'(outs()), 32'h00);
        end
    endtask

    task automatic enter_run();
        cyc();
        k = 0;
        check("run_start", 32'(outs()), 32'(run_vec(0, 1'b1)));
    endtask

    task automatic run_to(input string tag, input int target, input logic lk);
        while (k < target) begin
            cyc();
            k++;
            check(tag, 32'(outs()), 32'(run_vec(k, lk)));
        end
    endtask

    initial begin
        // 1: reset held 3 cycles with enable high
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("in_reset", 32'(outs()), 32'h00);
`ifdef CLK_GEN_CHECK_EN
            check("err_reset", 32'(err), 32'h0);
`endif
        end
        reset = 1'b0;
        cyc();
        check("busy_after_release", 32'(outs()), 32'h01);

        // 2: remaining SETTLE cycles, then full waveforms over more than one clk_f period
        expect_settle(SETTLE_CYC - 1);
        enter_run();
        run_to("run_wave", 42, 1'b1);

        // 3: drop enable at cnt=10, drain to cnt=31, stop in IDLE
        enable = 1'b0;
        run_to("drain_wave", 63, 1'b0);
        expect_idle("drain_stop", 4);

        // 4: restart, drop at cnt=10, re-raise at cnt=20
        enable = 1'b1;
        expect_settle(SETTLE_CYC);
        enter_run();
        run_to("run2", 10, 1'b1);
        enable = 1'b0;
        run_to("drain2", 20, 1'b0);
        enable = 1'b1;
        run_to("reenter", 40, 1'b1);

        // re-entry request coinciding with cnt==all-ones in DRAIN
        enable = 1'b0;
        run_to("drain3", 63, 1'b0);
        enable = 1'b1;
        run_to("reenter_at_max", 77, 1'b1);

        // 5: async reset mid-RUN at cnt=13
        #1 reset = 1'b1;
        #1 check("async_reset", 32'(outs()), 32'h00);
        cyc();
        check("reset_held", 32'(outs()), 32'h00);
        reset = 1'b0;
        expect_settle(SETTLE_CYC);
        enter_run();
        run_to("restart", 5, 1'b1);

        // back to IDLE via reset with enable low
        enable = 1'b0;
        reset  = 1'b1;
        cyc();
        check("reset2", 32'(outs()), 32'h00);
        reset = 1'b0;
        expect_idle("idle_hold", 2);

        // 6: two-cycle enable pulse aborts SETTLE with no edges
        enable = 1'b1;
        expect_settle(2);
        enable = 1'b0;
        expect_idle("settle_abort", 4);

`ifdef CLK_GEN_CHECK_EN
        enable = 1'b1;
        expect_settle(SETTLE_CYC);
        enter_run();
        run_to("long_run", 260, 1'b1);
        check("err_clean", 32'(err), 32'h0);
        if (clk_2f) force dut.clk_2f = 1'b0;
        else        force dut.clk_2f = 1'b1;
        cyc();
        release dut.clk_2f;
        cyc();
        check("err_set", 32'(err), 32'h1);
        enable = 1'b0;
        repeat (40) cyc();
        check("err_sticky", 32'(err), 32'h1);
        reset = 1'b1;
        #1 check("err_cleared", 32'(err), 32'h0);
        cyc();
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
